// File: rtl/ofs_plat_avalon_mem_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ofs_plat_avalon_mem_burst_arbiter
// Brief   : Round-robin arbiter sharing one Avalon-MM sink between two sources,
//           with atomic write bursts and in-order read/write response routing.
//           Optional grant statistics: define OFS_PLAT_AVALON_MEM_ARB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ofs_plat_avalon_mem_burst_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int USER_WIDTH      = 4,
  parameter int RD_TRACK_DEPTH  = 32,
  parameter int WR_TRACK_DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       src0_read,
  input  logic                       src0_write,
  input  logic [ADDR_WIDTH-1:0]      src0_address,
  input  logic [BURST_CNT_WIDTH-1:0] src0_burstcount,
  input  logic [DATA_WIDTH-1:0]      src0_writedata,
  input  logic [DATA_WIDTH/8-1:0]    src0_byteenable,
  input  logic [USER_WIDTH-1:0]      src0_user,
  output logic                       src0_waitrequest,
  output logic                       src0_readdatavalid,
  output logic                       src0_writeresponsevalid,
  output logic [DATA_WIDTH-1:0]      src0_readdata,
  input  logic                       src1_read,
  input  logic                       src1_write,
  input  logic [ADDR_WIDTH-1:0]      src1_address,
  input  logic [BURST_CNT_WIDTH-1:0] src1_burstcount,
  input  logic [DATA_WIDTH-1:0]      src1_writedata,
  input  logic [DATA_WIDTH/8-1:0]    src1_byteenable,
  input  logic [USER_WIDTH-1:0]      src1_user,
  output logic                       src1_waitrequest,
  output logic                       src1_readdatavalid,
  output logic                       src1_writeresponsevalid,
  output logic [DATA_WIDTH-1:0]      src1_readdata,
  output logic                       snk_read,
  output logic                       snk_write,
  output logic [ADDR_WIDTH-1:0]      snk_address,
  output logic [BURST_CNT_WIDTH-1:0] snk_burstcount,
  output logic [DATA_WIDTH-1:0]      snk_writedata,
  output logic [DATA_WIDTH/8-1:0]    snk_byteenable,
  output logic [USER_WIDTH-1:0]      snk_user,
  input  logic                       snk_waitrequest,
  input  logic                       snk_readdatavalid,
  input  logic [DATA_WIDTH-1:0]      snk_readdata,
  input  logic                       snk_writeresponsevalid,
  output logic                       err_unexpected_rsp,
  output logic [31:0]                grant_cnt0,
  output logic [31:0]                grant_cnt1
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_lock = 1'b1;
  localparam int c_rd_aw = $clog2(RD_TRACK_DEPTH);
  localparam int c_wr_aw = $clog2(WR_TRACK_DEPTH);
  localparam logic [BURST_CNT_WIDTH-1:0] c_one = 1;

  logic [0:0]                 r_state, w_state_next;
  logic [BURST_CNT_WIDTH-1:0] r_beats_left, w_beats_left_next;
  logic                       r_owner, r_last_grant, r_err;
  logic                       w_sel, w_gnt_valid, w_sel_read, w_sel_write;
  logic                       w_elig0, w_elig1, w_accept, w_rd_push, w_wr_sop;
  logic [BURST_CNT_WIDTH-1:0] w_sel_bc;

  logic                       r_rd_src [RD_TRACK_DEPTH];
  logic [BURST_CNT_WIDTH-1:0] r_rd_bc  [RD_TRACK_DEPTH];
  logic [c_rd_aw:0]           r_rd_wp, r_rd_rp;
  logic [BURST_CNT_WIDTH-1:0] r_rd_beat;
  logic                       w_rd_empty, w_rd_full, w_rd_rsp, w_rd_last, w_rd_head;
  logic                       r_wr_src [WR_TRACK_DEPTH];
  logic [c_wr_aw:0]           r_wr_wp, r_wr_rp;
  logic                       w_wr_empty, w_wr_full, w_wr_rsp, w_wr_head;

  assign w_rd_empty = (r_rd_wp == r_rd_rp);
  assign w_rd_full  = (r_rd_wp[c_rd_aw] != r_rd_rp[c_rd_aw]) &&
                      (r_rd_wp[c_rd_aw-1:0] == r_rd_rp[c_rd_aw-1:0]);
  assign w_wr_empty = (r_wr_wp == r_wr_rp);
  assign w_wr_full  = (r_wr_wp[c_wr_aw] != r_wr_rp[c_wr_aw]) &&
                      (r_wr_wp[c_wr_aw-1:0] == r_wr_rp[c_wr_aw-1:0]);

  // A request is only eligible when its tracking FIFO can take the push.
  assign w_elig0 = src0_read ? !w_rd_full : (src0_write && !w_wr_full);
  assign w_elig1 = src1_read ? !w_rd_full : (src1_write && !w_wr_full);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_st_idle;
      r_beats_left <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_beats_left <= w_beats_left_next;
      if (w_accept) r_last_grant <= w_sel;
      if (w_wr_sop) r_owner      <= w_sel;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_beats_left_next = r_beats_left;
    case (r_state)
      c_st_idle: begin
        if (w_wr_sop && (w_sel_bc > c_one)) begin
          w_state_next      = c_st_lock;
          w_beats_left_next = w_sel_bc - c_one;
        end
      end
      c_st_lock: begin
        if (w_accept) begin
          w_beats_left_next = r_beats_left - c_one;
          if (r_beats_left == c_one) w_state_next = c_st_idle;
        end
      end
      default: w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_sel       = 1'b0;
    w_gnt_valid = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_gnt_valid = w_elig0 || w_elig1;
        if (w_elig0 && w_elig1) w_sel = ~r_last_grant;
        else                    w_sel = w_elig1;
      end
      c_st_lock: begin
        w_sel       = r_owner;
        w_gnt_valid = r_owner ? src1_write : src0_write;
      end
      default: ;
    endcase
    if (!reset_n) w_gnt_valid = 1'b0;
  end

  assign w_sel_read  = (r_state == c_st_idle) && (w_sel ? src1_read : src0_read);
  assign w_sel_write = !w_sel_read && (w_sel ? src1_write : src0_write);
  assign w_sel_bc    = w_sel ? src1_burstcount : src0_burstcount;
  assign w_accept    = w_gnt_valid && !snk_waitrequest;
  assign w_rd_push   = w_accept && w_sel_read;
  assign w_wr_sop    = w_accept && (r_state == c_st_idle) && !w_sel_read;

  assign snk_read       = w_gnt_valid && w_sel_read;
  assign snk_write      = w_gnt_valid && w_sel_write;
  assign snk_address    = w_sel ? src1_address    : src0_address;
  assign snk_burstcount = w_sel_bc;
  assign snk_writedata  = w_sel ? src1_writedata  : src0_writedata;
  assign snk_byteenable = w_sel ? src1_byteenable : src0_byteenable;
  assign snk_user       = w_sel ? src1_user       : src0_user;

  assign src0_waitrequest = !(w_gnt_valid && !w_sel) || snk_waitrequest;
  assign src1_waitrequest = !(w_gnt_valid &&  w_sel) || snk_waitrequest;

  // Read tracking: head entry pops on its final beat.
  assign w_rd_rsp  = snk_readdatavalid && !w_rd_empty;
  assign w_rd_head = r_rd_src[r_rd_rp[c_rd_aw-1:0]];
  assign w_rd_last = ((r_rd_beat + c_one) == r_rd_bc[r_rd_rp[c_rd_aw-1:0]]);

  always_ff @(posedge clk) begin
    if (w_rd_push) begin
      r_rd_src[r_rd_wp[c_rd_aw-1:0]] <= w_sel;
      r_rd_bc[r_rd_wp[c_rd_aw-1:0]]  <= w_sel_bc;
    end
    if (w_wr_sop) r_wr_src[r_wr_wp[c_wr_aw-1:0]] <= w_sel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_wp   <= '0;
      r_rd_rp   <= '0;
      r_rd_beat <= '0;
      r_wr_wp   <= '0;
      r_wr_rp   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_rd_push) r_rd_wp <= r_rd_wp + 1'b1;
      if (w_rd_rsp) begin
        if (w_rd_last) begin
          r_rd_rp   <= r_rd_rp + 1'b1;
          r_rd_beat <= '0;
        end else begin
          r_rd_beat <= r_rd_beat + c_one;
        end
      end
      if (w_wr_sop) r_wr_wp <= r_wr_wp + 1'b1;
      if (w_wr_rsp) r_wr_rp <= r_wr_rp + 1'b1;
      if ((snk_readdatavalid && w_rd_empty) || (snk_writeresponsevalid && w_wr_empty))
        r_err <= 1'b1;
    end
  end

  assign w_wr_rsp  = snk_writeresponsevalid && !w_wr_empty;
  assign w_wr_head = r_wr_src[r_wr_rp[c_wr_aw-1:0]];

  assign src0_readdatavalid      = w_rd_rsp && !w_rd_head;
  assign src1_readdatavalid      = w_rd_rsp &&  w_rd_head;
  assign src0_writeresponsevalid = w_wr_rsp && !w_wr_head;
  assign src1_writeresponsevalid = w_wr_rsp &&  w_wr_head;
  assign src0_readdata           = snk_readdata;
  assign src1_readdata           = snk_readdata;
  assign err_unexpected_rsp      = r_err;

`ifdef OFS_PLAT_AVALON_MEM_ARB_STATS_EN
  logic [31:0] r_cnt0, r_cnt1;
  logic        w_req_acc;
  assign w_req_acc = w_rd_push || w_wr_sop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_req_acc && !w_sel && (r_cnt0 != 32'hFFFF_FFFF)) r_cnt0 <= r_cnt0 + 32'd1;
      if (w_req_acc &&  w_sel && (r_cnt1 != 32'hFFFF_FFFF)) r_cnt1 <= r_cnt1 + 32'd1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule
`default_nettype wire
